// File: rtl/xor_crypt_if.sv
// Serial load and serial ciphertext handshake bundle for the XOR crypt sequencer.
interface xor_crypt_if;
    logic iSerial_bit;
    logic iSerial_valid;
    logic iSerial_sel;
    logic iSerial_ready;
    logic oSerial_bit;
    logic oSerial_valid;

    modport master (
        output iSerial_bit, iSerial_valid, iSerial_sel, iSerial_ready,
        input  oSerial_bit, oSerial_valid
    );

    modport slave (
        input  iSerial_bit, iSerial_valid, iSerial_sel, iSerial_ready,
        output oSerial_bit, oSerial_valid
    );
endinterface

// File: rtl/xor_crypt_ctrl.sv
// Sequencer for the XOR encryption engine: serial key/message load, engine run with
// watchdog, serial ciphertext output with valid/ready, then a one-cycle engine clear.
module xor_crypt_ctrl #(
    parameter int MSG_BITS   = 64,
    parameter int KEY_BITS   = 8,
    parameter int ENC_CYCLES = 8,
    parameter int TIMEOUT    = 128
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    xor_crypt_if.slave                        ser,
    input  logic                              iKeep_key,
    input  logic [6:0]                        iEnc_counter,
    input  logic [MSG_BITS-1:0]               iCiphertext,
    output logic [MSG_BITS-1:0]               oMessage,
    output logic [KEY_BITS-1:0]               oKey,
    output logic [$clog2(MSG_BITS+1)-1:0]     oMessage_bit_counter,
    output logic [$clog2(KEY_BITS+1)-1:0]     oKey_bit_counter,
    output logic                              oEng_ena,
    output logic                              oEng_rst_n,
    output logic                              oBusy,
    output logic                              oDone,
    output logic                              oError
);
    localparam int MCW = $clog2(MSG_BITS + 1);
    localparam int KCW = $clog2(KEY_BITS + 1);
    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [6:0] ENC_DONE = 7'(ENC_CYCLES);

    typedef enum logic [1:0] {IDLE, ENCRYPT, SHIFT_OUT, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [MCW-1:0]      mcnt_q, mcnt_d;
    logic [KCW-1:0]      kcnt_q, kcnt_d;
    logic [MSG_BITS-1:0] out_q, out_d;
    logic [MCW-1:0]      ocnt_q, ocnt_d;
    logic [WDW-1:0]      wdog_q, wdog_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                eng_rst_n_q, eng_rst_n_d;
    logic                msg_full, key_full;

    assign msg_full = (mcnt_q == MCW'(MSG_BITS));
    assign key_full = (kcnt_q == KCW'(KEY_BITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            key_q       <= '0;
            mcnt_q      <= '0;
            kcnt_q      <= '0;
            out_q       <= '0;
            ocnt_q      <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            eng_rst_n_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            key_q       <= key_d;
            mcnt_q      <= mcnt_d;
            kcnt_q      <= kcnt_d;
            out_q       <= out_d;
            ocnt_q      <= ocnt_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            done_q      <= done_d;
            eng_rst_n_q <= eng_rst_n_d;
        end
    end

    // With ena low every next-state term keeps its default, freezing the whole block.
    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        key_d       = key_q;
        mcnt_d      = mcnt_q;
        kcnt_d      = kcnt_q;
        out_d       = out_q;
        ocnt_d      = ocnt_q;
        wdog_d      = wdog_q;
        err_d       = err_q;
        done_d      = done_q;
        eng_rst_n_d = eng_rst_n_q;
        if (ena) begin
            unique case (state_q)
                IDLE: begin
                    wdog_d = '0;
                    if (msg_full && key_full) begin
                        state_d = ENCRYPT;
                    end else if (ser.iSerial_valid) begin
                        if (ser.iSerial_sel && !msg_full) begin
                            msg_d  = {msg_q[MSG_BITS-2:0], ser.iSerial_bit};
                            mcnt_d = mcnt_q + MCW'(1);
                            err_d  = 1'b0;
                        end else if (!ser.iSerial_sel && !key_full) begin
                            key_d  = {key_q[KEY_BITS-2:0], ser.iSerial_bit};
                            kcnt_d = kcnt_q + KCW'(1);
                            err_d  = 1'b0;
                        end
                    end
                end
                ENCRYPT: begin
                    if (iEnc_counter == ENC_DONE) begin
                        out_d   = iCiphertext;
                        ocnt_d  = '0;
                        state_d = SHIFT_OUT;
                    end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = CLEAR;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
                SHIFT_OUT: begin
                    if (ser.iSerial_ready) begin
                        out_d  = {out_q[MSG_BITS-2:0], 1'b0};
                        ocnt_d = ocnt_q + MCW'(1);
                        if (ocnt_q == MCW'(MSG_BITS - 1)) begin
                            state_d = CLEAR;
                        end
                    end
                end
                CLEAR: begin
                    msg_d  = '0;
                    mcnt_d = '0;
                    if (!iKeep_key) begin
                        key_d  = '0;
                        kcnt_d = '0;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Registered so both strobes line up exactly with the CLEAR cycle.
            done_d      = (state_d == CLEAR);
            eng_rst_n_d = (state_d != CLEAR);
        end
    end

    assign oMessage             = msg_q;
    assign oKey                 = key_q;
    assign oMessage_bit_counter = mcnt_q;
    assign oKey_bit_counter     = kcnt_q;
    assign oEng_ena             = ena && (state_q == ENCRYPT);
    assign oEng_rst_n           = eng_rst_n_q;
    assign oBusy                = (state_q != IDLE);
    assign oDone                = done_q;
    assign oError               = err_q;
    assign ser.oSerial_bit      = out_q[MSG_BITS-1];
    assign ser.oSerial_valid    = ena && (state_q == SHIFT_OUT);
endmodule

// File: tb/tb_xor_crypt_ctrl.sv
// Bench for xor_crypt_ctrl: engine stand-in, directed vectors plus randomized traffic,
// ciphertext compared against a bitwise XOR reference.
module tb_xor_crypt_ctrl;
    logic        clk = 1'b0;
    logic        rst_n, ena, iKeep_key;
    logic [6:0]  iEnc_counter;
    logic [63:0] iCiphertext;
    logic [63:0] oMessage;
    logic [7:0]  oKey;
    logic [6:0]  oMessage_bit_counter;
    logic [3:0]  oKey_bit_counter;
    logic        oEng_ena, oEng_rst_n, oBusy, oDone, oError;
    logic [6:0]  eng_cnt;
    logic        force0 = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;

    localparam logic [63:0] MSG_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A   = 64'hA486E0C22C0E684A;
    localparam logic [63:0] MSG_FF = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] CT_FF  = 64'h5A5A5A5A5A5A5A5A;

    xor_crypt_if ser();

    xor_crypt_ctrl dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .ena                  (ena),
        .ser                  (ser),
        .iKeep_key            (iKeep_key),
        .iEnc_counter         (iEnc_counter),
        .iCiphertext          (iCiphertext),
        .oMessage             (oMessage),
        .oKey                 (oKey),
        .oMessage_bit_counter (oMessage_bit_counter),
        .oKey_bit_counter     (oKey_bit_counter),
        .oEng_ena             (oEng_ena),
        .oEng_rst_n           (oEng_rst_n),
        .oBusy                (oBusy),
        .oDone                (oDone),
        .oError               (oError)
    );

    always #5 clk = ~clk;

    // Engine stand-in: counts enabled cycles, cleared by its reset, XORs repeated key.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)              eng_cnt <= '0;
        else if (!oEng_rst_n)    eng_cnt <= '0;
        else if (oEng_ena)       eng_cnt <= eng_cnt + 7'd1;
    end
    assign iEnc_counter = force0 ? 7'd0 : eng_cnt;
    assign iCiphertext  = oMessage ^ {8{oKey}};

    function automatic logic [63:0] ref_cipher(input logic [7:0] k, input logic [63:0] m);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = m[i] ^ k[i % 8];
        return r;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_msg"},   oMessage, 64'(0));
        check_eq({tag, "_key"},   64'(oKey), 64'(0));
        check_eq({tag, "_mcnt"},  64'(oMessage_bit_counter), 64'(0));
        check_eq({tag, "_kcnt"},  64'(oKey_bit_counter), 64'(0));
        check_eq({tag, "_engena"}, 64'(oEng_ena), 64'(0));
        check_eq({tag, "_engrst"}, 64'(oEng_rst_n), 64'(1));
        check_eq({tag, "_sbit"},  64'(ser.oSerial_bit), 64'(0));
        check_eq({tag, "_svld"},  64'(ser.oSerial_valid), 64'(0));
        check_eq({tag, "_busy"},  64'(oBusy), 64'(0));
        check_eq({tag, "_done"},  64'(oDone), 64'(0));
        check_eq({tag, "_err"},   64'(oError), 64'(0));
    endtask

    task automatic send_bit(input logic sel, input logic b, input bit rand_gap);
        if (rand_gap) repeat ($urandom_range(0, 2)) step();
        ser.iSerial_sel   = sel;
        ser.iSerial_bit   = b;
        ser.iSerial_valid = 1'b1;
        step();
        ser.iSerial_valid = 1'b0;
    endtask

    // order: 0 key first, 1 message first, 2 interleaved with a surplus ninth key bit
    task automatic load(input logic [7:0] k, input logic [63:0] m, input int order,
                        input bit with_key, input bit rand_gap);
        if (!with_key) begin
            for (int i = 63; i >= 0; i--) send_bit(1'b1, m[i], rand_gap);
        end else if (order == 2) begin
            for (int i = 0; i < 8; i++) begin
                send_bit(1'b0, k[7-i], rand_gap);
                send_bit(1'b1, m[63-i], rand_gap);
            end
            send_bit(1'b0, 1'($urandom_range(0, 1)), rand_gap);
            for (int i = 55; i >= 0; i--) send_bit(1'b1, m[i], rand_gap);
        end else if (order == 1) begin
            for (int i = 63; i >= 0; i--) send_bit(1'b1, m[i], rand_gap);
            for (int i = 7; i >= 0; i--) send_bit(1'b0, k[i], rand_gap);
        end else begin
            for (int i = 7; i >= 0; i--) send_bit(1'b0, k[i], rand_gap);
            for (int i = 63; i >= 0; i--) send_bit(1'b1, m[i], rand_gap);
        end
        check_eq("load_key",  64'(oKey), 64'(k));
        check_eq("load_msg",  oMessage, m);
        check_eq("load_mcnt", 64'(oMessage_bit_counter), 64'(64));
        check_eq("load_kcnt", 64'(oKey_bit_counter), 64'(8));
        check_eq("load_idle", 64'(oBusy), 64'(0));
        step();
        check_eq("enc_entry_busy", 64'(oBusy), 64'(1));
        check_eq("enc_entry_ena",  64'(oEng_ena), 64'(1));
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0,1, 2 random ready
    task automatic run_out(input logic [63:0] exp, input int mode, input int ena_drop,
                           input bit keep);
        logic [63:0] got;
        logic        rdy, prev_bit, hb;
        bit          prev_stall, dropped;
        int          ntx, k, guard, first, last, dn;
        got = '0; ntx = 0; k = 0; guard = 0; first = -1; last = -1;
        prev_stall = 0; dropped = 0; prev_bit = 0;
        while (ntx < 64 && guard < 3000) begin
            if (!dropped && ena_drop >= 0 && ntx == ena_drop && ser.oSerial_valid) begin
                hb  = ser.oSerial_bit;
                ena = 1'b0;
                #1;
                check_eq("ena_low_valid", 64'(ser.oSerial_valid), 64'(0));
                repeat (10) begin
                    step();
                    check_eq("ena_hold_valid", 64'(ser.oSerial_valid), 64'(0));
                    check_eq("ena_hold_bit",   64'(ser.oSerial_bit), 64'(hb));
                    check_eq("ena_hold_busy",  64'(oBusy), 64'(1));
                end
                ena = 1'b1;
                #1;
                dropped = 1;
                check_eq("ena_resume_bit", 64'(ser.oSerial_bit), 64'(hb));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 4 == 0) || (k % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ser.iSerial_ready = rdy;
            ser.iSerial_valid = 1'($urandom_range(0, 1));
            ser.iSerial_sel   = 1'($urandom_range(0, 1));
            ser.iSerial_bit   = 1'($urandom_range(0, 1));
            if (ser.oSerial_valid) begin
                if (prev_stall) check_eq("stall_stable", 64'(ser.oSerial_bit), 64'(prev_bit));
                if (rdy) begin
                    got = {got[62:0], ser.oSerial_bit};
                    ntx++;
                    if (first < 0) first = guard;
                    last = guard;
                    prev_stall = 0;
                end else begin
                    prev_stall = 1;
                    prev_bit   = ser.oSerial_bit;
                end
                k++;
            end
            step();
            guard++;
        end
        ser.iSerial_valid = 1'b0;
        if (ntx < 64) check_eq("out_bound", 64'(ntx), 64'(64));
        check_eq("ciphertext", got, exp);
        if (mode == 0) check_eq("out_span", 64'(last - first + 1), 64'(64));
        check_eq("valid_drop", 64'(ser.oSerial_valid), 64'(0));
        dn = 0;
        repeat (4) begin
            if (oDone) dn++;
            step();
        end
        check_eq("done_pulses", 64'(dn), 64'(1));
        check_eq("idle_after",  64'(oBusy), 64'(0));
        check_eq("msg_cleared", 64'(oMessage_bit_counter), 64'(0));
        check_eq("kcnt_after",  64'(oKey_bit_counter), keep ? 64'(8) : 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  rk;
        logic [63:0] rm;
        int          enacnt, vcnt, dn, guard;
        rst_n = 1'b0; ena = 1'b1; iKeep_key = 1'b0;
        ser.iSerial_bit = 1'b0; ser.iSerial_valid = 1'b0;
        ser.iSerial_sel = 1'b0; ser.iSerial_ready = 1'b0;
        repeat (3) step();
        check_reset("reset");
        rst_n = 1'b1;
        step();

        load(8'hA5, MSG_A, 0, 1, 0);
        run_out(CT_A, 0, -1, 0);

        load(8'hA5, MSG_A, 2, 1, 0);
        run_out(CT_A, 0, -1, 0);

        iKeep_key = 1'b1;
        load(8'hA5, MSG_A, 1, 1, 1);
        run_out(CT_A, 1, -1, 1);
        check_eq("kept_key", 64'(oKey), 64'(8'hA5));
        iKeep_key = 1'b0;

        load(8'hA5, MSG_FF, 0, 0, 0);
        run_out(CT_FF, 0, -1, 0);

        for (int t = 0; t < 3; t++) begin
            rk = 8'($urandom);
            rm = {$urandom(), $urandom()};
            load(rk, rm, int'($urandom_range(0, 2)), 1, 1);
            run_out(ref_cipher(rk, rm), 2, -1, 0);
        end

        rk = 8'($urandom);
        rm = {$urandom(), $urandom()};
        load(rk, rm, 0, 1, 0);
        run_out(ref_cipher(rk, rm), 2, 20, 0);

        force0 = 1'b1;
        rk = 8'($urandom);
        rm = {$urandom(), $urandom()};
        load(rk, rm, 2, 1, 1);
        enacnt = 0; vcnt = 0; dn = 0; guard = 0;
        while (oBusy && guard < 400) begin
            if (oEng_ena) enacnt++;
            if (ser.oSerial_valid) vcnt++;
            if (oDone) dn++;
            step();
            guard++;
        end
        force0 = 1'b0;
        check_eq("to_cycles", 64'(enacnt), 64'(128));
        check_eq("to_no_out", 64'(vcnt), 64'(0));
        check_eq("to_done",   64'(dn), 64'(1));
        check_eq("to_error",  64'(oError), 64'(1));
        check_eq("to_idle",   64'(oBusy), 64'(0));
        send_bit(1'b1, 1'b1, 0);
        check_eq("to_err_clr", 64'(oError), 64'(0));
        check_eq("to_mcnt1",   64'(oMessage_bit_counter), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        rk = 8'($urandom);
        rm = {$urandom(), $urandom()};
        load(rk, rm, 1, 1, 0);
        ser.iSerial_ready = 1'b1;
        guard = 0;
        while (!ser.oSerial_valid && guard < 50) begin
            step();
            guard++;
        end
        check_eq("mid_reset_reached", 64'(ser.oSerial_valid), 64'(1));
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_reset("mid_reset");
        step();
        rst_n = 1'b1;
        step();

        load(8'hA5, MSG_A, 0, 1, 1);
        run_out(CT_A, 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xor_crypt_ctrl.md
Name: xor_crypt_ctrl

Overview:
Sequencer for the 64-bit/8-bit XOR encryption engine.
- Deserialises key and message bits from a single serial input and presents them to the engine together with its bit counters.
- Enables the engine, waits for it to finish, captures the ciphertext and serialises it out with a valid/ready handshake.
- Re-arms the engine for the next message, with an optional key hold.

Parameters:
MSG_BITS, 64, message width; width of the message shift register and the ciphertext output shift register.
KEY_BITS, 8, key width.
ENC_CYCLES, 8, value of the engine ciphertext counter that marks encryption complete.
TIMEOUT, 128, maximum ENCRYPT cycles before error abort.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  global enable; low freezes all state
iSerial_bit  in  1  serial load data, MSB first
iSerial_valid  in  1  iSerial_bit valid this cycle
iSerial_sel  in  1  0 = key bit, 1 = message bit
iKeep_key  in  1  sampled in CLEAR; 1 retains key across messages
iEnc_counter  in  7  engine ciphertext counter
iCiphertext  in  64  engine ciphertext
iSerial_ready  in  1  downstream accepts oSerial_bit
oMessage  out  64  message to engine
oKey  out  8  key to engine
oMessage_bit_counter  out  7  message bits loaded, 0..64
oKey_bit_counter  out  4  key bits loaded, 0..8
oEng_ena  out  1  engine enable
oEng_rst_n  out  1  registered active-low engine clear
oSerial_bit  out  1  ciphertext bit out, MSB first
oSerial_valid  out  1  oSerial_bit valid
oBusy  out  1  high in any state other than IDLE
oDone  out  1  one-cycle pulse on CLEAR exit
oError  out  1  sticky timeout flag

Behaviour:
- Reset (async, rst_n low): FSM=IDLE. All outputs 0 except oEng_rst_n=1. All internal registers 0.
- ena low: FSM, registers and counters hold; oEng_ena forced 0; oSerial_valid forced 0; no shift occurs. All other outputs hold.
- FSM states: IDLE, ENCRYPT, SHIFT_OUT, CLEAR.
- IDLE, loading: on iSerial_valid, shift the bit into the register selected by iSerial_sel (reg <= {reg[N-2:0], bit}) and increment its counter.
  - Counter saturation: counters saturate at 64 / 8. Bits arriving for an already-full register are dropped.
  - First accepted bit after CLEAR clears oError.
- IDLE -> ENCRYPT: on the cycle after both counters are full. Key and message may arrive interleaved or in either order.
- ENCRYPT:
  - oEng_ena=1.
  - When iEnc_counter == ENC_CYCLES: latch iCiphertext into the output shift register, oEng_ena <= 0, go to SHIFT_OUT.
  - Watchdog: counts ENCRYPT cycles. If TIMEOUT cycles elapse without completion, set oError=1 and go to CLEAR with no output.
- SHIFT_OUT:
  - oSerial_valid=1; oSerial_bit = shift register MSB.
  - A bit transfers on a cycle where valid && iSerial_ready; the register then shifts left and the out counter increments.
  - After the 64th transfer, go to CLEAR; oSerial_valid drops in the same edge.
  - iSerial_ready low stalls indefinitely with oSerial_bit stable.
- CLEAR (exactly one cycle):
  - oEng_rst_n=0.
  - Message register and message counter cleared.
  - If iKeep_key=1: key and key counter retained. Otherwise both are cleared.
  - Next state IDLE; oDone=1 for that one cycle (also on a timeout abort).
- Serial input while oBusy=1: ignored.
- Simultaneous events:
  - In IDLE, the bit completing the last counter is accepted; the transition occurs on the next edge.
  - With iKeep_key=1, the next message alone triggers ENCRYPT.
- Reset mid-operation: immediate return to reset values. Any partial load or output is discarded.
- Latency: last load bit to ENCRYPT entry is 1 cycle. Engine completion to first oSerial_valid is 1 cycle.

Test Plan:
- Basic encrypt:
  - Stimulus: key 0xA5, message 0x0123456789ABCDEF with engine connected, iSerial_ready=1.
  - Response: serial out 0xA486E0C22C0E684A over 64 consecutive cycles, then oDone pulse; oBusy low afterwards.
- Interleaved load:
  - Stimulus: alternate key/message bits of the same vectors.
  - Response: same ciphertext; ENCRYPT entered 1 cycle after final bit; 9th key bit dropped (oKey stays 0xA5).
- Backpressure:
  - Stimulus: iSerial_ready toggled 1,0,0,1 repeatedly.
  - Response: exactly 64 transfers; oSerial_bit stable during stalls; output equals 0xA486E0C22C0E684A.
- Key hold:
  - Stimulus: iKeep_key=1, then message 0xFFFFFFFFFFFFFFFF only.
  - Response: oKey_bit_counter stays 8; output 0x5A5A5A5A5A5A5A5A.
- Timeout:
  - Stimulus: iEnc_counter forced 0.
  - Response: after 128 ENCRYPT cycles oError=1, oDone pulse, no oSerial_valid; next load bit clears oError.
- Reset/ena:
  - Stimulus: ena low for 10 cycles mid-SHIFT_OUT.
  - Response: state held, remaining bits unchanged after resume.
  - Stimulus: rst_n low mid-SHIFT_OUT.
  - Response: all outputs at reset values, oEng_rst_n=1.
